// File: rtl/ctl_ammo.sv
// Ammunition controller: 2-digit BCD ammo count, shot gating, dry-fire pulse and timed reload.
// Optional hit bonus enabled by defining CTL_AMMO_BONUS_EN.
module ctl_ammo #(
    parameter int AMMO_INIT     = 34,
    parameter int RELOAD_CYCLES = 6500000,
    parameter int BONUS_AMMO    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shot_fired,
    input  logic       hit,
    input  logic       new_round,
    output logic [3:0] ammo_ones,
    output logic [3:0] ammo_tens,
    output logic       ammo_empty,
    output logic       shot_allowed,
    output logic       dry_fire
);

    typedef enum logic [1:0] {READY, EMPTY, RELOAD} state_t;

    localparam int             CNT_W      = (RELOAD_CYCLES > 1) ? $clog2(RELOAD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELOAD_CYCLES - 1);
    localparam logic [7:0]     INIT_BCD   = {4'(AMMO_INIT / 10), 4'(AMMO_INIT % 10)};
    localparam state_t         INIT_STATE = (AMMO_INIT == 0) ? EMPTY : READY;
    localparam logic           INIT_EMPTY = (AMMO_INIT == 0);
    localparam logic [3:0]     B_ONES     = 4'(BONUS_AMMO % 10);
    localparam logic [3:0]     B_TENS     = 4'(BONUS_AMMO / 10);

    state_t           state_q, state_d;
    logic [7:0]       count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             shot_q;
    logic             empty_q, empty_d;
    logic             allowed_q, allowed_d;
    logic             dry_q, dry_d;
    logic             shot_rise;
    logic             hit_rise;

    // Saturating BCD decrement: 00 stays 00.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00)
            return 8'h00;
        else if (v[3:0] != 4'd0)
            return {v[7:4], v[3:0] - 4'd1};
        else
            return {v[7:4] - 4'd1, 4'd9};
    endfunction

`ifdef CTL_AMMO_BONUS_EN
    logic hit_q;

    // BCD add of the bonus with decimal carry, clamped at 99.
    function automatic logic [7:0] bcd_add_sat(input logic [7:0] v);
        logic [4:0] o;
        logic [4:0] t;
        o = {1'b0, v[3:0]} + {1'b0, B_ONES};
        t = {1'b0, v[7:4]} + {1'b0, B_TENS};
        if (o > 5'd9) begin
            o = o - 5'd10;
            t = t + 5'd1;
        end
        if (t > 5'd9)
            return 8'h99;
        return {t[3:0], o[3:0]};
    endfunction

    assign hit_rise = hit & ~hit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hit_q <= 1'b0;
        else     hit_q <= hit;
    end
`else
    logic unused_hit;
    assign hit_rise   = 1'b0;
    assign unused_hit = &{1'b0, hit, B_ONES, B_TENS};
`endif

    assign shot_rise = shot_fired & ~shot_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        dry_d   = 1'b0;
        case (state_q)
            READY, EMPTY: begin
                if (new_round) begin
                    state_d = RELOAD;
                    cnt_d   = '0;
                end else begin
                    if (shot_rise) begin
                        if (state_q == READY) count_d = bcd_dec(count_d);
                        else                  dry_d   = 1'b1;
                    end
`ifdef CTL_AMMO_BONUS_EN
                    if (hit_rise) count_d = bcd_add_sat(count_d);
`endif
                    state_d = (count_d == 8'h00) ? EMPTY : READY;
                end
            end
            RELOAD: begin
                // A new_round here restarts the delay and swallows any shot.
                if (new_round) begin
                    cnt_d = '0;
                end else begin
                    dry_d = shot_rise;
                    if (cnt_q == CNT_LAST) begin
                        count_d = INIT_BCD;
                        state_d = INIT_STATE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = INIT_STATE;
                count_d = INIT_BCD;
                cnt_d   = '0;
            end
        endcase
        empty_d   = (count_d == 8'h00);
        allowed_d = (state_d == READY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT_STATE;
            count_q   <= INIT_BCD;
            cnt_q     <= '0;
            shot_q    <= 1'b0;
            empty_q   <= INIT_EMPTY;
            allowed_q <= ~INIT_EMPTY;
            dry_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cnt_q     <= cnt_d;
            shot_q    <= shot_fired;
            empty_q   <= empty_d;
            allowed_q <= allowed_d;
            dry_q     <= dry_d;
        end
    end

    assign ammo_ones    = count_q[3:0];
    assign ammo_tens    = count_q[7:4];
    assign ammo_empty   = empty_q;
    assign shot_allowed = allowed_q;
    assign dry_fire     = dry_q;

endmodule
